// File: rtl/ula_arbitro.sv
// Round-robin (or fixed-priority) arbiter for two command ports sharing one ULA.
// Runs one operation at a time and returns the result on a tagged response port.
module ula_arbitro #(
    parameter int W     = 8,
    parameter int OP_W  = 3,
    parameter bit RR_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [W-1:0]    req0_a,
    input  logic [W-1:0]    req0_b,
    input  logic [OP_W-1:0] req0_op,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [W-1:0]    req1_a,
    input  logic [W-1:0]    req1_b,
    input  logic [OP_W-1:0] req1_op,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [W-1:0]    rsp_s,
    output logic            rsp_flag,
    output logic [W-1:0]    alu_a,
    output logic [W-1:0]    alu_b,
    output logic [OP_W-1:0] alu_op,
    input  logic [W-1:0]    alu_s,
    input  logic            alu_flag,
    output logic            busy
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPT,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic [W-1:0]    alu_a_q, alu_a_d;
    logic [W-1:0]    alu_b_q, alu_b_d;
    logic [OP_W-1:0] alu_op_q, alu_op_d;
    logic            rsp_id_q, rsp_id_d;
    logic [W-1:0]    rsp_s_q, rsp_s_d;
    logic            rsp_flag_q, rsp_flag_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            grant_valid;
    logic            grant_id;

    // With both ports asking, the port that did not win last time goes next.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = RR_EN ? ~last_grant_q : 1'b0;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_id_d     = rsp_id_q;
        rsp_s_d      = rsp_s_q;
        rsp_flag_d   = rsp_flag_q;
        rsp_valid_d  = rsp_valid_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Ready is withheld during reset so no requester sees a phantom accept.
                if (grant_valid && rst_n) begin
                    req0_ready   = ~grant_id;
                    req1_ready   = grant_id;
                    alu_a_d      = grant_id ? req1_a  : req0_a;
                    alu_b_d      = grant_id ? req1_b  : req0_b;
                    alu_op_d     = grant_id ? req1_op : req0_op;
                    rsp_id_d     = grant_id;
                    last_grant_d = grant_id;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                rsp_flag_d = alu_flag;
                state_d    = S_CAPT;
            end
            S_CAPT: begin
                rsp_s_d     = alu_s;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_id_q     <= 1'b0;
            rsp_s_q      <= '0;
            rsp_flag_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_id_q     <= rsp_id_d;
            rsp_s_q      <= rsp_s_d;
            rsp_flag_q   <= rsp_flag_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_s     = rsp_s_q;
    assign rsp_flag  = rsp_flag_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ula_arbitro.sv
// Bench for ula_arbitro: directed scenarios plus random traffic, checked against a
// transaction-level model and a stand-in ULA with registered operands and result.
module tb_ula_arbitro;
    localparam int W    = 8;
    localparam int OP_W = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0]    req0_a, req0_b, req1_a, req1_b;
    logic [OP_W-1:0] req0_op, req1_op;
    logic            rsp_valid, rsp_ready, rsp_id, rsp_flag, busy;
    logic [W-1:0]    rsp_s, alu_a, alu_b, alu_s;
    logic [OP_W-1:0] alu_op;
    logic            alu_flag;

    logic            f_v0, f_v1, f_r0, f_r1, f_rsp_valid, f_rsp_ready, f_rsp_id, f_rsp_flag, f_busy;
    logic [W-1:0]    f_a0, f_b0, f_a1, f_b1, f_rsp_s, f_alu_a, f_alu_b, f_alu_s;
    logic [OP_W-1:0] f_op0, f_op1, f_alu_op;
    logic            f_alu_flag;

    int n_checks = 0;
    int n_errors = 0;

    ula_arbitro #(.W(W), .OP_W(OP_W), .RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_s(rsp_s), .rsp_flag(rsp_flag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_s(alu_s), .alu_flag(alu_flag), .busy(busy)
    );

    ula_arbitro #(.W(W), .OP_W(OP_W), .RR_EN(1'b0)) dut_fixed (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(f_v0), .req0_ready(f_r0), .req0_a(f_a0), .req0_b(f_b0), .req0_op(f_op0),
        .req1_valid(f_v1), .req1_ready(f_r1), .req1_a(f_a1), .req1_b(f_b1), .req1_op(f_op1),
        .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_id(f_rsp_id), .rsp_s(f_rsp_s), .rsp_flag(f_rsp_flag),
        .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_op(f_alu_op), .alu_s(f_alu_s), .alu_flag(f_alu_flag), .busy(f_busy)
    );

    // ULA function: bit W is carry (add) or borrow (sub), zero for everything else.
    function automatic logic [W:0] ula_f(input logic [W-1:0] a, input logic [W-1:0] b, input logic [OP_W-1:0] op);
        logic [W:0] ea, eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        case (op)
            3'd0:    return ea + eb;
            3'd1:    return ea - eb;
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {1'b0, ~(a & b)};
            3'd6:    return {1'b0, ~(a ^ b)};
            default: return {1'b0, a - b};
        endcase
    endfunction

    logic [W-1:0] ua_q, ub_q, fa_q, fb_q;
    logic [W:0]   u_res, f_res;
    assign u_res      = ula_f(ua_q, ub_q, alu_op);
    assign f_res      = ula_f(fa_q, fb_q, f_alu_op);
    assign alu_flag   = u_res[W];
    assign f_alu_flag = f_res[W];
    always @(posedge clk) begin
        ua_q    <= alu_a;
        ub_q    <= alu_b;
        alu_s   <= u_res[W-1:0];
        fa_q    <= f_alu_a;
        fb_q    <= f_alu_b;
        f_alu_s <= f_res[W-1:0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction model: at most one op in flight, response due 4 cycles after accept.
    int              cyc = 0;
    int              m_acc = 0;
    bit              m_known = 0;
    bit              m_inflight = 0;
    logic            m_last = 1'b1;
    logic [W-1:0]    m_a = '0, m_b = '0, m_s = '0;
    logic [OP_W-1:0] m_op = '0;
    logic            m_id = 1'b0, m_flag = 1'b0;

    always @(negedge clk) begin : monitor
        logic       e0, e1, erv;
        logic [W:0] r;
        e0  = rst_n && !m_inflight && req0_valid && (!req1_valid || m_last);
        e1  = rst_n && !m_inflight && req1_valid && (!req0_valid || !m_last);
        erv = m_inflight && ((cyc - m_acc) >= 4);
        if (m_known) begin
            check("ready0", req0_ready, e0);
            check("ready1", req1_ready, e1);
            check("busy", busy, m_inflight);
            check("rsp_valid", rsp_valid, erv);
            check("alu_a", alu_a, m_a);
            check("alu_b", alu_b, m_b);
            check("alu_op", alu_op, m_op);
            if (erv) begin
                check("rsp_id", rsp_id, m_id);
                check("rsp_s", rsp_s, m_s);
                check("rsp_flag", rsp_flag, m_flag);
            end
        end
        if (!rst_n) begin
            m_known    = 1;
            m_inflight = 0;
            m_last     = 1'b1;
            m_a        = '0;
            m_b        = '0;
            m_op       = '0;
        end else if (m_known) begin
            if (erv && rsp_ready) begin
                m_inflight = 0;
                $display("rsp id=%0d s=%02h flag=%0d cycle=%0d", m_id, m_s, m_flag, cyc);
            end else if (e0 || e1) begin
                m_id       = e1;
                m_last     = e1;
                m_a        = e1 ? req1_a : req0_a;
                m_b        = e1 ? req1_b : req0_b;
                m_op       = e1 ? req1_op : req0_op;
                r          = ula_f(m_a, m_b, m_op);
                m_s        = r[W-1:0];
                m_flag     = r[W];
                m_acc      = cyc;
                m_inflight = 1;
            end
        end
        cyc++;
    end

    task automatic send(input bit p, input logic [W-1:0] a, input logic [W-1:0] b, input logic [OP_W-1:0] op);
        bit ok;
        ok = 0;
        if (p) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = p ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
            @(posedge clk); #1;
        end
        check("send_accept", ok, 1'b1);
        if (p) req1_valid = 1'b0;
        else   req0_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output logic id, output logic [W-1:0] s, output logic fl);
        bit got;
        got = 0; lat = 0; id = 1'b0; s = '0; fl = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin
                got = 1; id = rsp_id; s = rsp_s; fl = rsp_flag;
            end
            @(posedge clk); #1;
        end
        check("rsp_arrived", got, 1'b1);
    endtask

    task automatic drain();
        bit idle;
        idle = 0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 40 && !idle; i++) begin
            @(negedge clk);
            idle = !busy;
            @(posedge clk); #1;
        end
        check("drain_idle", idle, 1'b1);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int           lat, n0, n1, g, fg;
        logic         id, fl;
        logic [W-1:0] s;
        bit           acc0, acc1, seen1;

        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22; req0_op = 3'd0;
        req1_valid = 1'b1; req1_a = 8'h33; req1_b = 8'h44; req1_op = 3'd1;
        f_v0 = 1'b0; f_v1 = 1'b0; f_rsp_ready = 1'b1;
        f_a0 = 8'hF0; f_b0 = 8'h20; f_op0 = 3'd0;
        f_a1 = 8'h0F; f_b1 = 8'h01; f_op1 = 3'd4;

        // Reset with both valids high
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready0", req0_ready, 1'b0);
        check("rst_ready1", req1_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_alu_a", alu_a, 8'h00);
        check("rst_alu_b", alu_b, 8'h00);
        check("rst_alu_op", alu_op, 3'd0);
        check("rst_rsp_s", rsp_s, 8'h00);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;

        // Single add on port 0
        rsp_ready = 1'b1;
        send(1'b0, 8'hF0, 8'h20, 3'd0);
        wait_rsp(lat, id, s, fl);
        check("t2_latency", lat, 4);
        check("t2_rsp_s", s, 8'h10);
        check("t2_rsp_flag", fl, 1'b1);
        check("t2_rsp_id", id, 1'b0);

        // Round-robin on main instance, fixed priority on the second one
        reset_dut();
        req0_valid = 1'b1; req0_a = W'($urandom); req0_b = W'($urandom); req0_op = OP_W'($urandom);
        req1_valid = 1'b1; req1_a = 8'hCC; req1_b = 8'hAA; req1_op = 3'd2;
        f_v0 = 1'b1; f_v1 = 1'b1;
        n0 = 0; n1 = 0; g = 0; fg = 0; seen1 = 0;
        for (int c = 0; c < 200 && (n0 < 4 || n1 < 4 || busy); c++) begin
            @(negedge clk);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            if (acc0 || acc1) begin
                check("t3_grant_order", acc1, g % 2);
                g++;
            end
            if (rsp_valid && rsp_id && !seen1) begin
                check("t3_and_s", rsp_s, 8'h88);
                check("t3_and_flag", rsp_flag, 1'b0);
                seen1 = 1;
            end
            check("t3_fixed_ready1", f_r1, 1'b0);
            if (f_v0 && f_r0) fg++;
            if (f_rsp_valid) begin
                check("t3_fixed_id", f_rsp_id, 1'b0);
                check("t3_fixed_s", f_rsp_s, 8'h10);
                check("t3_fixed_flag", f_rsp_flag, 1'b1);
            end
            @(posedge clk); #1;
            if (acc0) begin
                n0++;
                if (n0 < 4) begin req0_a = W'($urandom); req0_b = W'($urandom); req0_op = OP_W'($urandom); end
                else req0_valid = 1'b0;
            end
            if (acc1) begin
                n1++;
                if (n1 < 4) begin req1_a = W'($urandom); req1_b = W'($urandom); req1_op = OP_W'($urandom); end
                else req1_valid = 1'b0;
            end
        end
        f_v0 = 1'b0; f_v1 = 1'b0;
        check("t3_ops_done", n0 + n1, 8);
        check("t3_seen_port1", seen1, 1'b1);
        check("t3_fixed_grants", fg >= 4, 1'b1);
        drain();

        // Backpressure in RESP
        rsp_ready = 1'b0;
        send(1'b0, 8'h7E, 8'h81, 3'd0);
        wait_rsp(lat, id, s, fl);
        check("t4_latency", lat, 4);
        req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02; req0_op = 3'd3;
        req1_valid = 1'b1; req1_a = 8'h03; req1_b = 8'h04; req1_op = 3'd4;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t4_hold_valid", rsp_valid, 1'b1);
            check("t4_hold_s", rsp_s, s);
            check("t4_hold_id", rsp_id, id);
            check("t4_hold_flag", rsp_flag, fl);
            check("t4_ready0", req0_ready, 1'b0);
            check("t4_ready1", req1_ready, 1'b0);
            check("t4_busy", busy, 1'b1);
            @(posedge clk); #1;
        end
        check("t4_s_value", s, 8'hFF);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t4_hs_no_ready", req0_ready | req1_ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t4_next_accept", req0_ready | req1_ready, 1'b1);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        // alu_op stable while port 1 presents a different opcode
        reset_dut();
        rsp_ready = 1'b1;
        req1_valid = 1'b1; req1_a = W'($urandom); req1_b = W'($urandom); req1_op = 3'd0;
        send(1'b0, 8'h10, 8'h30, 3'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_alu_op", alu_op, 3'd1);
            @(posedge clk); #1;
        end
        wait_rsp(lat, id, s, fl);
        req1_valid = 1'b0;
        check("t5_rsp_id", id, 1'b0);
        check("t5_rsp_s", s, 8'hE0);
        check("t5_borrow", fl, 1'b1);
        drain();

        // Reset while the op is in WAIT
        send(1'b1, 8'h12, 8'h34, 3'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t6_no_rsp", rsp_valid, 1'b0);
            @(posedge clk); #1;
        end
        req0_valid = 1'b1; req0_a = 8'h55; req0_b = 8'h0F; req0_op = 3'd4;
        req1_valid = 1'b1; req1_a = 8'h66; req1_b = 8'h01; req1_op = 3'd0;
        @(negedge clk);
        check("t6_grant0", req0_ready, 1'b1);
        check("t6_no_grant1", req1_ready, 1'b0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp(lat, id, s, fl);
        check("t6_latency", lat, 4);
        check("t6_rsp_id", id, 1'b0);
        check("t6_rsp_s", s, 8'h5A);
        drain();

        // Random traffic, including requests withdrawn before grant
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            if (acc0 || !req0_valid) begin
                req0_valid = ($urandom % 2) == 0;
                req0_a = W'($urandom); req0_b = W'($urandom); req0_op = OP_W'($urandom);
            end else if (($urandom % 16) == 0) begin
                req0_valid = 1'b0;
            end
            if (acc1 || !req1_valid) begin
                req1_valid = ($urandom % 2) == 0;
                req1_a = W'($urandom); req1_b = W'($urandom); req1_op = OP_W'($urandom);
            end else if (($urandom % 16) == 0) begin
                req1_valid = 1'b0;
            end
            rsp_ready = ($urandom % 4) != 0;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
